// File: rtl/mem_bus_arbiter.sv
// Memory-port arbiter: the CPU owns the port by default, DMA masters borrow it via HOLD/HOLD_ACK.
// Every ownership change costs one dead cycle; a sticky watchdog reports over-long tenures.
module mem_bus_arbiter #(
  parameter int NREQ     = 2,
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_HOLD = 4096
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cpu_we,
  input  logic [AW-1:0]      cpu_addr,
  input  logic [DW-1:0]      cpu_wdata,
  output logic [DW-1:0]      cpu_rdata,
  output logic               cpu_stall,
  input  logic [NREQ-1:0]    dma_hold,
  output logic [NREQ-1:0]    dma_hold_ack,
  input  logic [NREQ-1:0]    dma_we,
  input  logic [NREQ*AW-1:0] dma_addr,
  input  logic [NREQ*DW-1:0] dma_wdata,
  output logic [DW-1:0]      dma_rdata,
  output logic               mem_we,
  output logic [AW-1:0]      mem_addr,
  output logic [DW-1:0]      mem_wdata,
  input  logic [DW-1:0]      mem_rdata,
  output logic               tmo_flag,
  output logic [2:0]         tmo_id,
  input  logic               tmo_clr
);

  localparam int WW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD + 1) : 1;

  typedef enum logic [1:0] {CPU_OWN, HANDOVER, DMA_OWN, RELEASE} state_t;

  state_t          r_state, w_state_next;
  logic [WW-1:0]   r_w, w_w_next;
  logic [WW-1:0]   r_rr_ptr, w_rr_ptr_next;
  logic [WW-1:0]   w_winner;
  logic [NREQ-1:0] r_ack, w_ack_next;
  logic [CW-1:0]   r_cnt, w_cnt_next;
  logic            r_tmo_flag, w_tmo_flag_next;
  logic [2:0]      r_tmo_id, w_tmo_id_next;
  logic            w_trip;

  // Round-robin pick: scan offsets high to low so the nearest requester above rr_ptr wins last.
  always_comb begin
    int idx;
    idx      = 0;
    w_winner = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = (int'(r_rr_ptr) + i) % NREQ;
      if (dma_hold[idx]) w_winner = WW'(idx);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= CPU_OWN;
      r_w        <= '0;
      r_rr_ptr   <= '0;
      r_ack      <= '0;
      r_cnt      <= '0;
      r_tmo_flag <= 1'b0;
      r_tmo_id   <= '0;
    end else begin
      r_state    <= w_state_next;
      r_w        <= w_w_next;
      r_rr_ptr   <= w_rr_ptr_next;
      r_ack      <= w_ack_next;
      r_cnt      <= w_cnt_next;
      r_tmo_flag <= w_tmo_flag_next;
      r_tmo_id   <= w_tmo_id_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_w_next        = r_w;
    w_rr_ptr_next   = r_rr_ptr;
    w_ack_next      = r_ack;
    w_cnt_next      = r_cnt;
    w_trip          = 1'b0;
    mem_we          = 1'b0;
    mem_addr        = cpu_addr;
    mem_wdata       = cpu_wdata;
    cpu_stall       = 1'b1;

    unique case (r_state)
      CPU_OWN: begin
        cpu_stall = 1'b0;
        mem_we    = cpu_we;
        if (|dma_hold) begin
          w_w_next     = w_winner;
          w_state_next = HANDOVER;
        end
      end
      HANDOVER: begin
        if (dma_hold[r_w]) begin
          w_state_next    = DMA_OWN;
          w_ack_next      = '0;
          w_ack_next[r_w] = 1'b1;
        end else begin
          w_state_next = CPU_OWN;
        end
      end
      DMA_OWN: begin
        mem_we    = dma_we[r_w];
        mem_addr  = dma_addr[int'(r_w)*AW +: AW];
        mem_wdata = dma_wdata[int'(r_w)*DW +: DW];
        // Saturating tenure count; the trip fires only on the cycle it reaches the limit.
        if (MAX_HOLD != 0 && r_cnt != CW'(MAX_HOLD)) begin
          w_cnt_next = r_cnt + 1'b1;
          w_trip     = (r_cnt + 1'b1 == CW'(MAX_HOLD));
        end
        if (!dma_hold[r_w]) begin
          w_state_next  = RELEASE;
          w_ack_next    = '0;
          w_cnt_next    = '0;
          w_rr_ptr_next = (int'(r_w) == NREQ - 1) ? '0 : r_w + 1'b1;
        end
      end
      RELEASE: begin
        w_state_next = CPU_OWN;
      end
      default: begin
        w_state_next = CPU_OWN;
      end
    endcase
  end

  // Sticky watchdog: a new trip beats a simultaneous clear, and the first offender's id is kept.
  always_comb begin
    w_tmo_flag_next = r_tmo_flag;
    w_tmo_id_next   = r_tmo_id;
    if (tmo_clr) w_tmo_flag_next = 1'b0;
    if (w_trip) begin
      w_tmo_flag_next = 1'b1;
      if (!r_tmo_flag) w_tmo_id_next = 3'(r_w);
    end
  end

  assign dma_hold_ack = r_ack;
  assign cpu_rdata    = mem_rdata;
  assign dma_rdata    = mem_rdata;
  assign tmo_flag     = r_tmo_flag;
  assign tmo_id       = r_tmo_id;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter (NREQ=2, MAX_HOLD=8): handover latency, round-robin,
// aborted handover, watchdog and asynchronous reset mid-tenure.
module tb_mem_bus_arbiter;
  localparam int NREQ = 2;
  localparam int AW   = 32;
  localparam int DW   = 32;

  logic               clk = 1'b0;
  logic               rst;
  logic               cpu_we;
  logic [AW-1:0]      cpu_addr;
  logic [DW-1:0]      cpu_wdata;
  logic [DW-1:0]      cpu_rdata;
  logic               cpu_stall;
  logic [NREQ-1:0]    dma_hold;
  logic [NREQ-1:0]    dma_hold_ack;
  logic [NREQ-1:0]    dma_we;
  logic [NREQ*AW-1:0] dma_addr;
  logic [NREQ*DW-1:0] dma_wdata;
  logic [DW-1:0]      dma_rdata;
  logic               mem_we;
  logic [AW-1:0]      mem_addr;
  logic [DW-1:0]      mem_wdata;
  logic [DW-1:0]      mem_rdata;
  logic               tmo_flag;
  logic [2:0]         tmo_id;
  logic               tmo_clr;

  int n_cmp = 0;
  int n_err = 0;

  mem_bus_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .MAX_HOLD(8)) dut (
    .clk(clk), .rst(rst),
    .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_hold(dma_hold), .dma_hold_ack(dma_hold_ack), .dma_we(dma_we),
    .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_rdata(dma_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .tmo_flag(tmo_flag), .tmo_id(tmo_id), .tmo_clr(tmo_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [1:0]  t3_hold [20];
  logic [1:0]  t3_ack  [20];
  logic        t3_stall[20];
  logic [31:0] exp_addr;

  initial begin
    t3_hold  = '{2'b11, 2'b11, 2'b11, 2'b01, 2'b11, 2'b11, 2'b11, 2'b11, 2'b10, 2'b11,
                 2'b11, 2'b11, 2'b11, 2'b01, 2'b11, 2'b11, 2'b11, 2'b10, 2'b00, 2'b00};
    t3_ack   = '{2'b00, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00,
                 2'b00, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00};
    t3_stall = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1,
                 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    rst       = 1'b1;
    cpu_we    = 1'b0;
    cpu_addr  = 32'h0;
    cpu_wdata = 32'h0;
    dma_hold  = '0;
    dma_we    = '0;
    dma_addr  = {32'h0000_1000, 32'h0000_0200};
    dma_wdata = {32'hB000_0000, 32'hA000_0000};
    mem_rdata = 32'h1234_5678;
    tmo_clr   = 1'b0;
    #1;
    chk("reset_ack", 64'(dma_hold_ack), 64'(2'b00));
    chk("reset_stall", 64'(cpu_stall), 64'(1'b0));
    chk("reset_tmo_flag", 64'(tmo_flag), 64'(1'b0));
    chk("reset_tmo_id", 64'(tmo_id), 64'(3'd0));
    step();
    step();
    rst = 1'b0;

    // Idle bus: CPU write passes straight through
    cpu_we = 1'b1; cpu_addr = 32'h100; cpu_wdata = 32'hDEAD_BEEF;
    #1;
    chk("cpu_mem_we", 64'(mem_we), 64'(1'b1));
    chk("cpu_mem_addr", 64'(mem_addr), 64'(32'h100));
    chk("cpu_mem_wdata", 64'(mem_wdata), 64'(32'hDEAD_BEEF));
    chk("cpu_stall_idle", 64'(cpu_stall), 64'(1'b0));
    chk("cpu_rdata", 64'(cpu_rdata), 64'(32'h1234_5678));
    chk("dma_rdata", 64'(dma_rdata), 64'(32'h1234_5678));
    step();

    // Master 0 tenure writing 0x200..0x203
    cpu_we = 1'b1; cpu_addr = 32'h300; cpu_wdata = 32'h3333;
    dma_hold = 2'b01; dma_we = 2'b01;
    #1;
    chk("t2_c0_stall", 64'(cpu_stall), 64'(1'b0));
    chk("t2_c0_ack", 64'(dma_hold_ack), 64'(2'b00));
    step();
    #1;
    chk("t2_c1_stall", 64'(cpu_stall), 64'(1'b1));
    chk("t2_c1_ack", 64'(dma_hold_ack), 64'(2'b00));
    chk("t2_c1_mem_we", 64'(mem_we), 64'(1'b0));
    chk("t2_c1_mem_addr", 64'(mem_addr), 64'(32'h300));
    for (int k = 0; k < 4; k++) begin
      step();
      dma_addr[31:0]  = 32'h200 + 32'(k);
      dma_wdata[31:0] = 32'hA000_0000 + 32'(k);
      if (k == 3) dma_hold = 2'b00;
      #1;
      chk($sformatf("t2_dma%0d_ack", k), 64'(dma_hold_ack), 64'(2'b01));
      chk($sformatf("t2_dma%0d_stall", k), 64'(cpu_stall), 64'(1'b1));
      chk($sformatf("t2_dma%0d_we", k), 64'(mem_we), 64'(1'b1));
      chk($sformatf("t2_dma%0d_addr", k), 64'(mem_addr), 64'(32'h200 + 32'(k)));
      chk($sformatf("t2_dma%0d_wdata", k), 64'(mem_wdata), 64'(32'hA000_0000 + 32'(k)));
    end
    dma_we = 2'b00; dma_addr[31:0] = 32'h200;
    step();
    #1;
    chk("t2_rel_ack", 64'(dma_hold_ack), 64'(2'b00));
    chk("t2_rel_stall", 64'(cpu_stall), 64'(1'b1));
    chk("t2_rel_mem_we", 64'(mem_we), 64'(1'b0));
    step();
    #1;
    chk("t2_cpu_stall", 64'(cpu_stall), 64'(1'b0));
    chk("t2_cpu_mem_we", 64'(mem_we), 64'(1'b1));
    cpu_we = 1'b0;
    step();

    // Both masters requesting: round-robin with a RELEASE + CPU_OWN gap (rr_ptr starts at 1)
    for (int c = 0; c < 20; c++) begin
      dma_hold = t3_hold[c];
      #1;
      exp_addr = (t3_ack[c] == 2'b10) ? 32'h1000 : (t3_ack[c] == 2'b01) ? 32'h200 : 32'h300;
      chk($sformatf("t3_c%0d_ack", c), 64'(dma_hold_ack), 64'(t3_ack[c]));
      chk($sformatf("t3_c%0d_stall", c), 64'(cpu_stall), 64'(t3_stall[c]));
      chk($sformatf("t3_c%0d_addr", c), 64'(mem_addr), 64'(exp_addr));
      step();
    end

    // One-cycle pulse on master 1: handover aborts, rr_ptr stays at 1
    dma_hold = 2'b10;
    #1;
    chk("t4_c0_stall", 64'(cpu_stall), 64'(1'b0));
    step();
    dma_hold = 2'b00;
    #1;
    chk("t4_c1_stall", 64'(cpu_stall), 64'(1'b1));
    chk("t4_c1_ack", 64'(dma_hold_ack), 64'(2'b00));
    step();
    dma_hold = 2'b11;
    #1;
    chk("t4_c2_stall", 64'(cpu_stall), 64'(1'b0));
    chk("t4_c2_ack", 64'(dma_hold_ack), 64'(2'b00));
    step();
    step();
    dma_hold = 2'b00;
    #1;
    chk("t4_rr_unchanged_ack", 64'(dma_hold_ack), 64'(2'b10));
    step();
    step();
    #1;
    chk("t4_back_cpu", 64'(cpu_stall), 64'(1'b0));
    step();

    // Watchdog: master 1 owns cycles 2..22 with MAX_HOLD=8
    for (int c = 0; c < 27; c++) begin
      dma_hold = (c <= 21) ? 2'b10 : 2'b00;
      tmo_clr  = (c == 24);
      #1;
      chk($sformatf("t5_c%0d_ack", c), 64'(dma_hold_ack),
          64'((c >= 2 && c <= 22) ? 2'b10 : 2'b00));
      chk($sformatf("t5_c%0d_stall", c), 64'(cpu_stall), 64'((c >= 1 && c <= 23) ? 1'b1 : 1'b0));
      chk($sformatf("t5_c%0d_flag", c), 64'(tmo_flag), 64'((c >= 10 && c <= 24) ? 1'b1 : 1'b0));
      if (c >= 10) chk($sformatf("t5_c%0d_id", c), 64'(tmo_id), 64'(3'd1));
      step();
    end
    tmo_clr = 1'b0;

    // Master 0 tenure moves rr_ptr to 1, then reset hits during master 1's tenure
    dma_hold = 2'b01;
    step();
    step();
    dma_hold = 2'b00;
    #1;
    chk("t6_m0_ack", 64'(dma_hold_ack), 64'(2'b01));
    step();
    step();
    dma_hold = 2'b10;
    step();
    step();
    #1;
    chk("t6_m1_ack", 64'(dma_hold_ack), 64'(2'b10));
    step();
    cpu_we = 1'b1; cpu_addr = 32'h400;
    dma_we = 2'b10;
    rst = 1'b1;
    #1;
    chk("t6_rst_ack", 64'(dma_hold_ack), 64'(2'b00));
    chk("t6_rst_stall", 64'(cpu_stall), 64'(1'b0));
    chk("t6_rst_mem_we", 64'(mem_we), 64'(1'b1));
    chk("t6_rst_mem_addr", 64'(mem_addr), 64'(32'h400));
    step();
    rst = 1'b0; cpu_we = 1'b0; dma_we = 2'b00;
    dma_hold = 2'b11;
    step();
    step();
    #1;
    chk("t6_post_rst_grant", 64'(dma_hold_ack), 64'(2'b01));
    dma_hold = 2'b00;
    step();
    step();
    #1;
    chk("t6_final_stall", 64'(cpu_stall), 64'(1'b0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single external memory port between the CPU (default owner) and NREQ DMA masters, such as the AES coprocessor's block DMA.
- Each DMA master requests with HOLD and receives HOLD_ACK.
- The arbiter inserts one dead cycle on every ownership change and picks round-robin among DMA requesters.
- A sticky tenure watchdog flags DMA masters that hold the bus too long; it never revokes a grant.

Parameters:
NREQ, 2, number of DMA requesters (1..8)
AW, 32, address width
DW, 32, data width
MAX_HOLD, 4096, tenure watchdog limit in cycles; 0 disables

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
cpu_we  in  1  CPU write enable
cpu_addr  in  AW  CPU address
cpu_wdata  in  DW  CPU write data
cpu_rdata  out  DW  memory read data to CPU
cpu_stall  out  1  CPU must freeze; its access is not performed
dma_hold  in  NREQ  per-master bus request
dma_hold_ack  out  NREQ  per-master grant, one-hot or zero, registered
dma_we  in  NREQ  per-master write enable
dma_addr  in  NREQ*AW  packed addresses, master k at [k*AW +: AW]
dma_wdata  in  NREQ*DW  packed write data
dma_rdata  out  DW  memory read data, broadcast to all masters
mem_we  out  1  memory write enable
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data
tmo_flag  out  1  sticky watchdog flag
tmo_id  out  3  index of the master that tripped the watchdog
tmo_clr  in  1  clears tmo_flag

Behaviour:
- States:
  - CPU_OWN: memory port muxed to CPU; cpu_stall=0.
  - HANDOVER: mem_we forced 0; cpu_stall=1.
  - DMA_OWN: memory port muxed to master w; cpu_stall=1.
  - RELEASE: mem_we forced 0; cpu_stall=1.
- Reset values:
  - state=CPU_OWN, dma_hold_ack=0, rr_ptr=0, w=0.
  - tenure counter=0, tmo_flag=0, tmo_id=0.
  - mem_* follow the CPU inputs combinationally.
- Outside DMA_OWN, mem_addr/mem_wdata always carry the CPU values. mem_we is cpu_we in CPU_OWN and 0 in HANDOVER and RELEASE.
- cpu_rdata and dma_rdata are both wired to mem_rdata.
- Winner selection:
  - The winner is the first set bit of dma_hold, searching upward from rr_ptr and wrapping modulo NREQ.
  - It is evaluated combinationally in CPU_OWN.
- CPU_OWN:
  - The CPU access in this cycle always completes.
  - If any dma_hold bit is set: latch w = winner, go to HANDOVER.
  - Otherwise stay.
- HANDOVER:
  - If dma_hold[w]=1: go to DMA_OWN and set dma_hold_ack[w]=1 on the same edge.
  - Otherwise: go back to CPU_OWN; no ack is issued and rr_ptr is unchanged.
- DMA_OWN:
  - mem_we/mem_addr/mem_wdata = dma_we[w]/dma_addr[w]/dma_wdata[w].
  - Tenure counter increments each cycle.
  - When dma_hold[w]=0 is sampled: that cycle's DMA signals are still passed through; the next state is RELEASE, dma_hold_ack cleared, rr_ptr = (w+1) mod NREQ, counter cleared.
- RELEASE: always returns to CPU_OWN. The CPU therefore owns at least one cycle between any two DMA tenures, even with back-to-back requests.
- Latency: hold rising in CPU_OWN (cycle 0) gives ack high from cycle 2 and the DMA owning the port from cycle 2. After hold falls, the CPU is unstalled 2 cycles later.
- Watchdog:
  - When MAX_HOLD≠0 and the counter reaches MAX_HOLD: tmo_flag←1 and tmo_id←w. Only the first trip is recorded while the flag is set.
  - The grant is kept; the counter saturates.
  - tmo_clr clears tmo_flag. If clear and set occur in the same cycle, set wins.
- Holds from non-owners are ignored during a tenure; they remain pending.
- dma_hold bits are assumed synchronous to clk.
- Asynchronous rst mid-tenure: ack drops immediately, state=CPU_OWN, and the in-flight DMA write is lost (mem_we follows cpu_we).

Test Plan:
- Idle bus, CPU writes addr 0x100 data 0xDEADBEEF -> mem_we=1, mem_addr=0x100 same cycle, cpu_stall=0 throughout.
- dma_hold[0] rises at cycle 0 -> cpu_stall=1 from cycle 1, dma_hold_ack[0]=1 at cycle 2; DMA writes 0x200..0x203 appear on mem_*; hold falls -> ack=0 next cycle, cpu_stall=0 two cycles after hold falls.
- dma_hold=2'b11 held continuously -> grants alternate 0,1,0,1; each tenure is separated by exactly one RELEASE cycle and one CPU_OWN cycle.
- dma_hold[1] pulses for one cycle only -> HANDOVER aborts, ack never asserted, rr_ptr unchanged, back in CPU_OWN after 2 cycles.
- MAX_HOLD=8, master 1 holds for 20 cycles -> tmo_flag=1 and tmo_id=1 after 8 owned cycles, grant kept to cycle 20; tmo_clr then gives tmo_flag=0.
- rst asserted during DMA_OWN -> dma_hold_ack=0 and cpu_stall=0 immediately; after release, a new hold is granted normally starting from rr_ptr=0.
